// File: rtl/pwm_channel.sv
// ============================================================================
// Module      : pwm_channel
// Description : Register-mapped single PWM output channel. Sits on the 8-bit
//               parallel register bus driven by the SPI slave bridge and
//               produces one registered PWM pin. Period and duty are double
//               buffered: the bus writes staging registers, and the active
//               copies are refreshed only at a period boundary (or when the
//               channel is started), so the waveform never glitches.
//
// Ports       : clk_i      system clock, rising edge
//               rst_i      asynchronous, active-high reset
//               b_addr_i   register bus address
//               b_data_i   register bus write data
//               b_write_i  write strobe, one clk_i cycle per write
//               b_data_o   register bus read data (combinational from address)
//               pwm_o      PWM output, registered
//
// Register map (offset from BASE_ADDR):
//               0 CTRL      rw  [0] EN, [1] INV
//               1 PRESCALE  rw
//               2 PERIOD_L  rw  staging
//               3 PERIOD_H  rw  staging
//               4 DUTY_L    rw  staging
//               5 DUTY_H    rw  staging
//               6 STATUS    ro  [0] PEND, [1] RUN
//               7 reserved, reads 0, writes ignored
//
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_channel #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         CNT_W     = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] b_addr_i,
    input  logic [7:0] b_data_i,
    input  logic       b_write_i,
    output logic [7:0] b_data_o,
    output logic       pwm_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] C_OFF_CTRL     = 3'd0;
    localparam logic [2:0] C_OFF_PRESCALE = 3'd1;
    localparam logic [2:0] C_OFF_PERIOD_L = 3'd2;
    localparam logic [2:0] C_OFF_PERIOD_H = 3'd3;
    localparam logic [2:0] C_OFF_DUTY_L   = 3'd4;
    localparam logic [2:0] C_OFF_DUTY_H   = 3'd5;
    localparam logic [2:0] C_OFF_STATUS   = 3'd6;

    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic             r_en;
    logic             r_inv;
    logic [7:0]       r_prescale;
    logic [CNT_W-1:0] r_period_stg;
    logic [CNT_W-1:0] r_duty_stg;
    logic [CNT_W-1:0] r_period_act;
    logic [CNT_W-1:0] r_duty_act;
    logic [7:0]       r_pcnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_pwm;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    // Subtracting the base first makes the window check a single test of the
    // upper offset bits; any address below the base wraps to a large offset
    // and is rejected the same way as one above the window.
    logic [7:0] w_off;
    logic       w_sel;
    logic [2:0] w_reg;
    logic       w_wr;
    logic       w_wr_ctrl;
    logic       w_wr_prescale;
    logic       w_wr_per_l;
    logic       w_wr_per_h;
    logic       w_wr_duty_l;
    logic       w_wr_duty_h;
    logic       w_wr_stage;

    assign w_off         = b_addr_i - BASE_ADDR;
    assign w_sel         = (w_off[7:3] == 5'd0);
    assign w_reg         = w_off[2:0];
    assign w_wr          = b_write_i & w_sel;
    assign w_wr_ctrl     = w_wr & (w_reg == C_OFF_CTRL);
    assign w_wr_prescale = w_wr & (w_reg == C_OFF_PRESCALE);
    assign w_wr_per_l    = w_wr & (w_reg == C_OFF_PERIOD_L);
    assign w_wr_per_h    = w_wr & (w_reg == C_OFF_PERIOD_H);
    assign w_wr_duty_l   = w_wr & (w_reg == C_OFF_DUTY_L);
    assign w_wr_duty_h   = w_wr & (w_reg == C_OFF_DUTY_H);
    assign w_wr_stage    = w_wr_per_l | w_wr_per_h | w_wr_duty_l | w_wr_duty_h;

    // EN as it will be after this edge. Steering the FSM from this value lets
    // a CTRL write move the state on the same edge that updates EN, so a
    // disable stops the counters immediately.
    logic w_en_nxt;
    assign w_en_nxt = w_wr_ctrl ? b_data_i[0] : r_en;

    // ------------------------------------------------------------------------
    // Control / staging registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en         <= 1'b0;
            r_inv        <= 1'b0;
            r_prescale   <= 8'd0;
            r_period_stg <= C_CNT_ZERO;
            r_duty_stg   <= C_CNT_ZERO;
        end else begin
            if (w_wr_ctrl) begin
                r_en  <= b_data_i[0];
                r_inv <= b_data_i[1];
            end
            if (w_wr_prescale) r_prescale               <= b_data_i;
            if (w_wr_per_l)    r_period_stg[7:0]        <= b_data_i;
            if (w_wr_per_h)    r_period_stg[CNT_W-1:8]  <= b_data_i;
            if (w_wr_duty_l)   r_duty_stg[7:0]          <= b_data_i;
            if (w_wr_duty_h)   r_duty_stg[CNT_W-1:8]    <= b_data_i;
        end
    end

    // ------------------------------------------------------------------------
    // Channel FSM
    // ------------------------------------------------------------------------
    state_t w_state_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_en_nxt) w_state_nxt = S_START;
            S_START: w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
        // Disabling wins from every state.
        if (!w_en_nxt) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler, period counter and shadow load
    // ------------------------------------------------------------------------
    logic w_running;
    logic w_tick;
    logic w_wrap;
    logic w_load;

    assign w_running = (r_state == S_RUN);
    assign w_tick    = w_running & (r_pcnt == r_prescale);
    assign w_wrap    = w_tick & (r_cnt == r_period_act);
    // Active registers refresh on START, or at a period wrap with an update
    // pending. The load samples the staging registers as they were before
    // this edge, so a coincident bus write lands in the following period.
    assign w_load    = (r_state == S_START) | (w_wrap & r_pend);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pcnt <= 8'd0;
            r_cnt  <= C_CNT_ZERO;
        end else if (!w_running || (w_state_nxt != S_RUN)) begin
            // IDLE and START hold the counters at zero; leaving RUN clears
            // them on the same edge.
            r_pcnt <= 8'd0;
            r_cnt  <= C_CNT_ZERO;
        end else begin
            // pcnt may sit above a freshly lowered PRESCALE; it then keeps
            // counting, wraps through 255 and meets the new value next lap.
            r_pcnt <= w_tick ? 8'd0 : (r_pcnt + 8'd1);
            if (w_tick) begin
                r_cnt <= w_wrap ? C_CNT_ZERO : (r_cnt + C_CNT_ONE);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_period_act <= C_CNT_ZERO;
            r_duty_act   <= C_CNT_ZERO;
        end else if (w_load) begin
            r_period_act <= r_period_stg;
            r_duty_act   <= r_duty_stg;
        end
    end

    // A staging write on the same edge as a load keeps PEND set: the value
    // just written has not reached the active registers yet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= 1'b0;
        end else if (w_wr_stage) begin
            r_pend <= 1'b1;
        end else if (w_load) begin
            r_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // PWM output
    // ------------------------------------------------------------------------
    // duty_act=0 never satisfies the compare (constant low); duty_act above
    // period_act always does (constant high).
    logic w_raw;
    assign w_raw = (r_cnt < r_duty_act);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pwm <= 1'b0;
        end else if (w_running) begin
            r_pwm <= w_raw ^ r_inv;
        end else begin
            r_pwm <= r_inv;
        end
    end

    assign pwm_o = r_pwm;

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    always_comb begin
        b_data_o = 8'h00;
        if (w_sel) begin
            case (w_reg)
                C_OFF_CTRL:     b_data_o = {6'd0, r_inv, r_en};
                C_OFF_PRESCALE: b_data_o = r_prescale;
                C_OFF_PERIOD_L: b_data_o = r_period_stg[7:0];
                C_OFF_PERIOD_H: b_data_o = r_period_stg[CNT_W-1:8];
                C_OFF_DUTY_L:   b_data_o = r_duty_stg[7:0];
                C_OFF_DUTY_H:   b_data_o = r_duty_stg[CNT_W-1:8];
                C_OFF_STATUS:   b_data_o = {6'd0, w_running, r_pend};
                default:        b_data_o = 8'h00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_channel.sv
// ============================================================================
// Module      : tb_pwm_channel
// Description : Directed self-checking bench for pwm_channel. Two instances
//               (BASE_ADDR 0x00 and 0x10) share one register bus.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_channel;

    logic       clk;
    logic       rst;
    logic [7:0] b_addr;
    logic [7:0] b_data;
    logic       b_write;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic       pwm0;
    logic       pwm1;

    int checks   = 0;
    int failures = 0;

    pwm_channel #(.BASE_ADDR(8'h00), .CNT_W(16)) u_ch0 (
        .clk_i     (clk),
        .rst_i     (rst),
        .b_addr_i  (b_addr),
        .b_data_i  (b_data),
        .b_write_i (b_write),
        .b_data_o  (rdata0),
        .pwm_o     (pwm0)
    );

    pwm_channel #(.BASE_ADDR(8'h10), .CNT_W(16)) u_ch1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .b_addr_i  (b_addr),
        .b_data_i  (b_data),
        .b_write_i (b_write),
        .b_data_o  (rdata1),
        .pwm_o     (pwm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge: the write lands on the next rising edge and
    // the task returns on the falling edge after it.
    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        b_addr  = a;
        b_data  = d;
        b_write = 1'b1;
        @(negedge clk);
        b_write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Program channel 0 and enable it last; returns on the falling edge
    // after the CTRL write edge (cycle index 0 in the tests below).
    task automatic setup(input logic [7:0] pre, input logic [15:0] per,
                         input logic [15:0] duty, input logic [7:0] ctrl);
        bus_wr(8'h01, pre);
        bus_wr(8'h02, per[7:0]);
        bus_wr(8'h03, per[15:8]);
        bus_wr(8'h04, duty[7:0]);
        bus_wr(8'h05, duty[15:8]);
        bus_wr(8'h00, ctrl);
    endtask

    task automatic test_reset();
        logic [7:0] exp_rd;
        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pwm0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_pwm_hold: got %b expected 0", pwm0);
        end
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            b_addr = 8'(a);
            #1;
            checks++;
            if (rdata0 !== 8'h00) begin
                failures++;
                $display("FAIL reset_read_%0d: got %02h expected 00", a, rdata0);
            end
        end
        @(negedge clk);
        // Mid-run asynchronous reset with PERIOD=9, DUTY=3
        setup(8'd0, 16'd9, 16'd3, 8'h01);
        for (int i = 1; i <= 3; i++) @(negedge clk);
        checks++;
        if (pwm0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_prerun_pwm: got %b expected 1", pwm0);
        end
        b_addr = 8'h06;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pwm0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_pwm: got %b expected 0", pwm0);
        end
        checks++;
        if (rdata0 !== 8'h00) begin
            failures++;
            $display("FAIL reset_async_status: got %02h expected 00", rdata0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            b_addr = 8'(a);
            #1;
            exp_rd = 8'h00;
            checks++;
            if (rdata0 !== exp_rd) begin
                failures++;
                $display("FAIL reset_release_read_%0d: got %02h expected %02h", a, rdata0, exp_rd);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pwm0 !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle_pwm: got %b expected 0", pwm0);
            end
        end
    endtask

    task automatic test_basic();
        logic exp_pwm;
        do_reset();
        setup(8'd0, 16'd9, 16'd3, 8'h01);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            exp_pwm = (i >= 2) && (((i - 2) % 10) < 3);
            checks++;
            if (pwm0 !== exp_pwm) begin
                failures++;
                $display("FAIL basic_pwm cycle %0d: got %b expected %b", i, pwm0, exp_pwm);
            end
            if (i == 5) begin
                b_addr = 8'h06;
                #1;
                checks++;
                if (rdata0 !== 8'h02) begin
                    failures++;
                    $display("FAIL basic_status: got %02h expected 02", rdata0);
                end
            end
        end
    endtask

    task automatic test_prescale_invert();
        logic exp_pwm;
        do_reset();
        setup(8'd3, 16'd4, 16'd2, 8'h03);
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (i == 1) exp_pwm = 1'b1;
            else        exp_pwm = !((((i - 2) / 4) % 5) < 2);
            checks++;
            if (pwm0 !== exp_pwm) begin
                failures++;
                $display("FAIL prescale_inv_pwm cycle %0d: got %b expected %b", i, pwm0, exp_pwm);
            end
        end
    endtask

    task automatic test_double_buffer();
        int   duty_tab[5] = '{3, 7, 7, 2, 5};
        logic exp_pwm;
        int   p;
        do_reset();
        setup(8'd0, 16'd9, 16'd3, 8'h01);
        for (int i = 1; i <= 51; i++) begin
            if (i == 6)       bus_wr(8'h04, 8'd7);
            else if (i == 25) bus_wr(8'h04, 8'd2);
            else if (i == 31) bus_wr(8'h04, 8'd5);   // exact wrap edge
            else              @(negedge clk);
            if (i < 2) begin
                exp_pwm = 1'b0;
            end else begin
                p = (i - 2) / 10;
                exp_pwm = (((i - 2) % 10) < duty_tab[p]);
            end
            checks++;
            if (pwm0 !== exp_pwm) begin
                failures++;
                $display("FAIL dbuf_pwm cycle %0d: got %b expected %b", i, pwm0, exp_pwm);
            end
            if (i == 6 || i == 12 || i == 31 || i == 42) begin
                b_addr = 8'h06;
                #1;
                checks++;
                if (rdata0 !== ((i == 6 || i == 31) ? 8'h03 : 8'h02)) begin
                    failures++;
                    $display("FAIL dbuf_status cycle %0d: got %02h expected %02h", i, rdata0,
                             ((i == 6 || i == 31) ? 8'h03 : 8'h02));
                end
            end
            if (i == 32) begin
                b_addr = 8'h04;
                #1;
                checks++;
                if (rdata0 !== 8'h05) begin
                    failures++;
                    $display("FAIL dbuf_duty_read: got %02h expected 05", rdata0);
                end
            end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] per_tab[3]  = '{16'd9, 16'h00FF, 16'd0};
        logic [15:0] duty_tab[3] = '{16'd0, 16'h0100, 16'd1};
        logic        exp_tab[3]  = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            setup(8'd0, per_tab[k], duty_tab[k], 8'h01);
            @(negedge clk);
            for (int i = 2; i <= 30; i++) begin
                @(negedge clk);
                checks++;
                if (pwm0 !== exp_tab[k]) begin
                    failures++;
                    $display("FAIL extreme_%0d cycle %0d: got %b expected %b", k, i, pwm0, exp_tab[k]);
                end
            end
        end
    endtask

    task automatic test_decode();
        do_reset();
        bus_wr(8'h12, 8'hAB);
        b_addr = 8'h12;
        #1;
        checks++;
        if (rdata1 !== 8'hAB) begin
            failures++;
            $display("FAIL decode_ch1_period: got %02h expected ab", rdata1);
        end
        checks++;
        if (rdata0 !== 8'h00) begin
            failures++;
            $display("FAIL decode_ch0_outside: got %02h expected 00", rdata0);
        end
        b_addr = 8'h02;
        #1;
        checks++;
        if (rdata0 !== 8'h00) begin
            failures++;
            $display("FAIL decode_ch0_period: got %02h expected 00", rdata0);
        end
        b_addr = 8'h16;
        #1;
        checks++;
        if (rdata1 !== 8'h01) begin
            failures++;
            $display("FAIL decode_ch1_pend: got %02h expected 01", rdata1);
        end
        b_addr = 8'h06;
        #1;
        checks++;
        if (rdata0 !== 8'h00) begin
            failures++;
            $display("FAIL decode_ch0_status: got %02h expected 00", rdata0);
        end
        @(negedge clk);
        bus_wr(8'h08, 8'hFF);
        b_addr = 8'h08;
        #1;
        checks++;
        if (rdata0 !== 8'h00) begin
            failures++;
            $display("FAIL decode_read_08: got %02h expected 00", rdata0);
        end
        b_addr = 8'h00;
        #1;
        checks++;
        if (rdata0 !== 8'h00) begin
            failures++;
            $display("FAIL decode_alias_ctrl: got %02h expected 00", rdata0);
        end
        @(negedge clk);
        bus_wr(8'h01, 8'h5A);
        b_addr = 8'h01;
        #1;
        checks++;
        if (rdata0 !== 8'h5A) begin
            failures++;
            $display("FAIL decode_prescale_rw: got %02h expected 5a", rdata0);
        end
        // CTRL upper bits read as zero; INV alone drives the idle level.
        @(negedge clk);
        bus_wr(8'h00, 8'hFE);
        b_addr = 8'h00;
        #1;
        checks++;
        if (rdata0 !== 8'h02) begin
            failures++;
            $display("FAIL decode_ctrl_mask: got %02h expected 02", rdata0);
        end
        checks++;
        if (pwm0 !== 1'b0) begin
            failures++;
            $display("FAIL inv_latency_before: got %b expected 0", pwm0);
        end
        @(negedge clk);
        checks++;
        if (pwm0 !== 1'b1) begin
            failures++;
            $display("FAIL inv_idle_level: got %b expected 1", pwm0);
        end
        checks++;
        if (pwm1 !== 1'b0) begin
            failures++;
            $display("FAIL decode_ch1_pwm: got %b expected 0", pwm1);
        end
    endtask

    initial begin
        rst     = 1'b1;
        b_addr  = 8'h00;
        b_data  = 8'h00;
        b_write = 1'b0;
        test_reset();
        test_basic();
        test_prescale_invert();
        test_double_buffer();
        test_extremes();
        test_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pwm_channel.md
Name: pwm_channel

Overview:
- Register-mapped single PWM output channel.
- Consumes the 8-bit parallel register bus (addr/wdata/rdata/write strobe) driven by the SPI slave bridge, and produces one PWM pin.
- Period and duty are double-buffered: staging registers are written by the bus; active registers are loaded only at a period boundary, so the output never glitches.
- One instance per channel; instances are distinguished by BASE_ADDR.

Parameters:
- BASE_ADDR, 8'h00, bus address of register offset 0. Block decodes BASE_ADDR..BASE_ADDR+7.
- CNT_W, 16, counter/period/duty width. Fixed at 16 for this register map.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- b_addr_i  in  8  register bus address.
- b_data_i  in  8  register bus write data.
- b_write_i  in  1  write strobe, one clk_i cycle per write.
- b_data_o  out  8  register bus read data.
- pwm_o  out  1  PWM output, registered.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 CTRL rw: [0] EN, [1] INV; [7:2] read 0.
  - 1 PRESCALE rw.
  - 2 PERIOD_L rw, staging.
  - 3 PERIOD_H rw, staging.
  - 4 DUTY_L rw, staging.
  - 5 DUTY_H rw, staging.
  - 6 STATUS ro: [0] PEND, [1] RUN.
  - 7 reads 8'h00; writes to it are ignored.
- Reset values: all registers, counters and active registers 0; PEND=0; pwm_o=0; b_data_o=0.
- Writes: a register updates on the rising edge where b_write_i=1 and the address matches. Writes outside the decoded range and writes to STATUS are ignored.
- Reads:
  - b_data_o is combinational from b_addr_i.
  - Out-of-range addresses return 8'h00.
  - PERIOD/DUTY reads return the staging values.
- PEND: set by any write to offsets 2..5; cleared when the shadow load occurs.
- Prescaler:
  - 8-bit counter pcnt. tick=1 when pcnt==PRESCALE, then pcnt returns to 0; otherwise pcnt increments.
  - One tick every PRESCALE+1 clocks. PRESCALE=0 gives a tick every clock.
- Period counter (16-bit cnt), advances on tick:
  - If cnt==period_act: cnt→0 and wrap=1.
  - Otherwise cnt→cnt+1.
  - PWM period is (period_act+1)*(PRESCALE+1) clocks.
- Shadow load:
  - Occurs on a tick with wrap while PEND=1: period_act←PERIOD, duty_act←DUTY, PEND→0.
  - Simultaneous bus write to 2..5 and load: the load takes the pre-write staging values, and PEND remains 1 (set wins over clear).
- States:
  - IDLE (EN=0): pcnt=0, cnt=0; pwm_o follows INV one cycle later; RUN=0.
  - START (EN 0→1 written): one cycle; loads active registers from staging, clears PEND, cnt=0, pcnt=0.
  - RUN: counting; RUN=1.
  - EN written 0 in any state → IDLE on the next edge; the counters clear.
- Output:
  - raw = (cnt < duty_act).
  - pwm_o registered: in RUN, raw^INV; otherwise INV.
  - Latency: one clock from cnt change to pwm_o.
  - The first RUN cycle outputs cnt=0 on the following edge.
- Boundaries:
  - duty_act=0: constant low (before INV).
  - duty_act > period_act: constant high.
  - period_act=0: cnt stays 0; output is high if duty_act≥1.
  - PRESCALE written mid-period: takes effect immediately. If pcnt > new PRESCALE, pcnt continues incrementing to 255, wraps to 0, and the comparison resumes.
  - INV change: takes effect on the next edge, with no shadowing.
- Async reset asserted mid-period: everything returns to reset values immediately; pwm_o=0 while rst_i=1.

Test Plan:
- Reset: rst_i pulsed mid-run with PERIOD=9, DUTY=3 → pwm_o=0 and STATUS=0 immediately; all reads return 0 after release.
- Basic PWM, PRESCALE=0: write PERIOD=9, DUTY=3, EN=1 → pwm_o repeats 3 clocks high / 7 low, period 10 clocks; STATUS.RUN=1.
- Prescale and invert: PRESCALE=3, PERIOD=4, DUTY=2, INV=1 → period 20 clocks; pwm_o low 8, high 12.
- Double buffering:
  - Mid-period, write DUTY=7 → STATUS.PEND=1, and the current period stays at 3-high.
  - The next period is 7-high, and PEND=0 after the wrap.
  - Also write DUTY_L on the exact wrap cycle → the old staging value loads and PEND stays 1.
- Extremes:
  - DUTY=0 → constant 0.
  - DUTY=0x0100 with PERIOD=0x00FF → constant 1.
  - PERIOD=0 with DUTY=1 → constant 1.
- Decode: two BASE_ADDR values (0x00, 0x10) on a shared bus → a write to 0x12 affects only the second instance; a read of 0x08 on the first returns 0x00.
